// File: rtl/fu_issue_arbiter_pkg.sv
// Shared definitions for the functional-unit issue arbiter: unit encoding,
// widths and the ROB-relative age helper.
package fu_issue_arbiter_pkg;

  localparam int NUM_FU  = 3;
  localparam int NUM_ENT = 32;
  localparam int IDX_W   = 5;
  localparam int ROB_W   = 5;
  localparam int FU_W    = 2;

  typedef enum logic [FU_W-1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MEM  = 2'd2,
    FU_NONE = 2'd3
  } fu_id_t;

  // Distance from the ROB head; the 5-bit subtraction wraps naturally.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] rob,
                                               input logic [ROB_W-1:0] head);
    return rob - head;
  endfunction

endpackage

// File: rtl/fu_issue_arbiter_oldest_select.sv
// Picks the eligible entry with the smallest age; ties resolve to the lowest
// entry index because only a strictly smaller age replaces the current pick.
module oldest_select
  import fu_issue_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            eligible,
  input  logic [N-1:0][ROB_W-1:0] ages,
  output logic                    found,
  output logic [IDX_W-1:0]        idx
);

  logic [ROB_W-1:0] best_age;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (!found || (ages[i] < best_age))) begin
        found    = 1'b1;
        best_age = ages[i];
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Oldest-first issue arbiter for two ALUs and one MEM unit; grants and the
// consumed-entry mask are registered one cycle after the sampled request.
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
#(
  parameter int NUM_ENT = fu_issue_arbiter_pkg::NUM_ENT,
  parameter int MEM_LAT = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_ENT-1:0]              req_valid,
  input  logic [NUM_ENT-1:0][FU_W-1:0]    req_fu,
  input  logic [NUM_ENT-1:0][ROB_W-1:0]   req_rob,
  input  logic [ROB_W-1:0]                rob_head,
  input  logic [NUM_FU-1:0]               fu_ready,
  input  logic                            flush,
  output logic [NUM_FU-1:0]               grant_valid,
  output logic [NUM_FU-1:0][IDX_W-1:0]    grant_idx,
  output logic [NUM_ENT-1:0]              grant_clear
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int MEM_K = int'(FU_MEM);

  logic [NUM_ENT-1:0][ROB_W-1:0]  age;
  logic [NUM_FU-1:0][NUM_ENT-1:0] elig;
  logic [NUM_FU-1:0]              unit_open;
  logic [NUM_FU-1:0]              found;
  logic [NUM_FU-1:0][IDX_W-1:0]   sel_idx;
  logic [NUM_ENT-1:0]             clear_next;
  logic [CNT_W-1:0]               mem_cnt;
  logic [CNT_W-1:0]               mem_cnt_next;
  logic                           mem_blocked;

  assign mem_blocked = (mem_cnt != '0);

  // grant_clear doubles as the one-cycle mask while the station drops inuse.
  always_comb begin
    unit_open = '0;
    elig      = '0;
    age       = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      age[i] = rob_age(req_rob[i], rob_head);
    end
    for (int k = 0; k < NUM_FU; k++) begin
      unit_open[k] = fu_ready[k] && !((k == MEM_K) && mem_blocked);
      for (int i = 0; i < NUM_ENT; i++) begin
        elig[k][i] = unit_open[k] && req_valid[i] && !grant_clear[i] &&
                     (req_fu[i] == FU_W'(k));
      end
    end
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_unit
    oldest_select #(
      .N(NUM_ENT)
    ) u_sel (
      .eligible(elig[k]),
      .ages    (age),
      .found   (found[k]),
      .idx     (sel_idx[k])
    );
  end

  always_comb begin
    clear_next = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (found[k]) begin
        clear_next[sel_idx[k]] = 1'b1;
      end
    end
  end

  always_comb begin
    mem_cnt_next = mem_cnt;
    if (found[MEM_K]) begin
      mem_cnt_next = CNT_W'(MEM_LAT - 1);
    end else if (mem_blocked) begin
      mem_cnt_next = mem_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= '0;
      grant_idx   <= '0;
      grant_clear <= '0;
      mem_cnt     <= '0;
    end else if (flush) begin
      grant_valid <= '0;
      grant_clear <= '0;
      mem_cnt     <= '0;
    end else begin
      grant_valid <= found;
      grant_clear <= clear_next;
      mem_cnt     <= mem_cnt_next;
      for (int k = 0; k < NUM_FU; k++) begin
        if (found[k]) begin
          grant_idx[k] <= sel_idx[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Scenario bench for fu_issue_arbiter: each task drives one scenario and
// queues the registered outputs it expects for the following cycle.
module tb_fu_issue_arbiter;

  localparam int NE = 32;

  logic              clk;
  logic              reset;
  logic [NE-1:0]     req_valid;
  logic [NE-1:0][1:0] req_fu;
  logic [NE-1:0][4:0] req_rob;
  logic [4:0]        rob_head;
  logic [2:0]        fu_ready;
  logic              flush;
  logic [2:0]        grant_valid;
  logic [2:0][4:0]   grant_idx;
  logic [NE-1:0]     grant_clear;

  typedef struct {
    logic [2:0]      gv;
    logic [2:0][4:0] gi;
    logic [NE-1:0]   gc;
    string           name;
  } exp_t;

  exp_t            sb[$];
  logic [2:0][4:0] exp_idx;
  int              tests_run = 0;
  int              tests_failed = 0;

  fu_issue_arbiter #(
    .NUM_ENT(NE),
    .MEM_LAT(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_fu     (req_fu),
    .req_rob    (req_rob),
    .rob_head   (rob_head),
    .fu_ready   (fu_ready),
    .flush      (flush),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .grant_clear(grant_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle_inputs();
    req_valid = '0;
    for (int i = 0; i < NE; i++) begin
      req_fu[i]  = 2'd3;
      req_rob[i] = 5'd0;
    end
    rob_head = 5'd0;
    fu_ready = 3'b111;
    flush    = 1'b0;
  endtask

  task automatic set_req(input int e, input logic [1:0] fu, input logic [4:0] rob);
    req_valid[e] = 1'b1;
    req_fu[e]    = fu;
    req_rob[e]   = rob;
  endtask

  // Units without a grant keep their previous index in the expectation.
  task automatic expect_cycle(input logic [2:0] gv, input logic [4:0] i0,
                              input logic [4:0] i1, input logic [4:0] i2,
                              input logic [NE-1:0] gc, input string nm);
    exp_t e;
    if (gv[0]) exp_idx[0] = i0;
    if (gv[1]) exp_idx[1] = i1;
    if (gv[2]) exp_idx[2] = i2;
    e.gv   = gv;
    e.gi   = exp_idx;
    e.gc   = gc;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic cycle_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: output cycle with no expectation queued");
    end else begin
      e = sb.pop_front();
      tests_run++;
      if (grant_valid !== e.gv) begin
        tests_failed++;
        $display("[TB] FAIL %s grant_valid: got %b expected %b", e.name, grant_valid, e.gv);
      end
      tests_run++;
      if (grant_idx !== e.gi) begin
        tests_failed++;
        $display("[TB] FAIL %s grant_idx: got %0d/%0d/%0d expected %0d/%0d/%0d", e.name,
                 grant_idx[0], grant_idx[1], grant_idx[2], e.gi[0], e.gi[1], e.gi[2]);
      end
      tests_run++;
      if (grant_clear !== e.gc) begin
        tests_failed++;
        $display("[TB] FAIL %s grant_clear: got %h expected %h", e.name, grant_clear, e.gc);
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset   = 1'b1;
    exp_idx = '0;
    expect_cycle(3'b000, 0, 0, 0, '0, "reset_cycle");
    cycle_check();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    flush = 1'b1;
    set_req(3, 2'd0, 5'd0);
    set_req(4, 2'd2, 5'd1);
    exp_idx = '0;
    expect_cycle(3'b000, 0, 0, 0, '0, "reset_priority_1");
    cycle_check();
    expect_cycle(3'b000, 0, 0, 0, '0, "reset_priority_2");
    cycle_check();
    reset = 1'b0;
    idle_inputs();
    expect_cycle(3'b000, 0, 0, 0, '0, "idle_after_reset");
    cycle_check();
  endtask

  task automatic test_age_order();
    do_reset();
    set_req(3, 2'd0, 5'd7);
    set_req(9, 2'd0, 5'd2);
    expect_cycle(3'b001, 9, 0, 0, 32'd1 << 9, "age_first");
    cycle_check();
    expect_cycle(3'b001, 3, 0, 0, 32'd1 << 3, "age_second");
    cycle_check();
    req_valid[3] = 1'b0;
    req_valid[9] = 1'b0;
    expect_cycle(3'b000, 0, 0, 0, '0, "age_drain");
    cycle_check();
  endtask

  task automatic test_wrap();
    do_reset();
    rob_head = 5'd30;
    set_req(1, 2'd1, 5'd31);
    set_req(2, 2'd1, 5'd1);
    expect_cycle(3'b010, 0, 1, 0, 32'd1 << 1, "wrap_first");
    cycle_check();
    req_valid[1] = 1'b0;
    expect_cycle(3'b010, 0, 2, 0, 32'd1 << 2, "wrap_second");
    cycle_check();
    req_valid[2] = 1'b0;
    set_req(6, 2'd1, 5'd5);
    set_req(4, 2'd1, 5'd5);
    expect_cycle(3'b010, 0, 4, 0, 32'd1 << 4, "tie_low_index");
    cycle_check();
    req_valid[4] = 1'b0;
    expect_cycle(3'b010, 0, 6, 0, 32'd1 << 6, "tie_next");
    cycle_check();
    idle_inputs();
    expect_cycle(3'b000, 0, 0, 0, '0, "wrap_drain");
    cycle_check();
  endtask

  task automatic test_mem_block();
    do_reset();
    set_req(10, 2'd2, 5'd3);
    set_req(11, 2'd2, 5'd4);
    expect_cycle(3'b100, 0, 0, 10, 32'd1 << 10, "mem_grant_a");
    cycle_check();
    expect_cycle(3'b000, 0, 0, 0, '0, "mem_blocked_1");
    cycle_check();
    req_valid[10] = 1'b0;
    expect_cycle(3'b000, 0, 0, 0, '0, "mem_blocked_2");
    cycle_check();
    expect_cycle(3'b100, 0, 0, 11, 32'd1 << 11, "mem_grant_b");
    cycle_check();
    req_valid[11] = 1'b0;
    set_req(12, 2'd2, 5'd5);
    reset   = 1'b1;
    exp_idx = '0;
    expect_cycle(3'b000, 0, 0, 0, '0, "mem_reset");
    cycle_check();
    reset = 1'b0;
    expect_cycle(3'b100, 0, 0, 12, 32'd1 << 12, "mem_after_reset");
    cycle_check();
    idle_inputs();
    expect_cycle(3'b000, 0, 0, 0, '0, "mem_drain");
    cycle_check();
  endtask

  task automatic test_double_grant();
    do_reset();
    set_req(5, 2'd0, 5'd0);
    expect_cycle(3'b001, 5, 0, 0, 32'd1 << 5, "dbl_grant");
    cycle_check();
    expect_cycle(3'b000, 0, 0, 0, '0, "dbl_masked");
    cycle_check();
    req_valid[5] = 1'b0;
    expect_cycle(3'b000, 0, 0, 0, '0, "dbl_quiet");
    cycle_check();
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(0, 2'd0, 5'd4);
    set_req(1, 2'd1, 5'd5);
    set_req(2, 2'd2, 5'd6);
    set_req(7, 2'd3, 5'd0);
    expect_cycle(3'b111, 0, 1, 2, 32'h0000_0007, "all_units");
    cycle_check();
    req_valid = '0;
    set_req(20, 2'd0, 5'd1);
    set_req(21, 2'd1, 5'd2);
    set_req(22, 2'd2, 5'd3);
    flush = 1'b1;
    expect_cycle(3'b000, 0, 0, 0, '0, "flush_kill");
    cycle_check();
    flush = 1'b0;
    expect_cycle(3'b111, 20, 21, 22, (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 22),
                 "after_flush");
    cycle_check();
    idle_inputs();
    expect_cycle(3'b000, 0, 0, 0, '0, "sim_drain");
    cycle_check();
  endtask

  task automatic test_fu_ready();
    do_reset();
    set_req(8, 2'd0, 5'd1);
    set_req(15, 2'd3, 5'd0);
    fu_ready = 3'b110;
    expect_cycle(3'b000, 0, 0, 0, '0, "not_ready_1");
    cycle_check();
    expect_cycle(3'b000, 0, 0, 0, '0, "not_ready_2");
    cycle_check();
    fu_ready = 3'b111;
    expect_cycle(3'b001, 8, 0, 0, 32'd1 << 8, "ready_grant");
    cycle_check();
    req_valid[8] = 1'b0;
    fu_ready = 3'b110;
    expect_cycle(3'b000, 0, 0, 0, '0, "fu3_ignored_1");
    cycle_check();
    fu_ready = 3'b111;
    expect_cycle(3'b000, 0, 0, 0, '0, "fu3_ignored_2");
    cycle_check();
    idle_inputs();
  endtask

  initial begin
    reset   = 1'b1;
    exp_idx = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_age_order();
    test_wrap();
    test_mem_block();
    test_double_grant();
    test_simultaneous();
    test_fu_ready();
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: %0d expectations never compared", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fu_issue_arbiter.md
FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_ENT, default 32: number of reservation-station entries arbitrated.
REQ-002 SHALL have parameter MEM_LAT, default 2: cycles the MEM unit stays blocked after a MEM grant (MEM_LAT >= 1).
REQ-003 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_ENT: entry i in use with all source operands ready.
REQ-006 SHALL have port req_fu, input, NUM_ENT x 2: target unit per entry (0 ALU0, 1 ALU1, 2 MEM, 3 invalid).
REQ-007 SHALL have port req_rob, input, NUM_ENT x 5: ROB index per entry.
REQ-008 SHALL have port rob_head, input, 5: ROB index of the oldest in-flight instruction.
REQ-009 SHALL have port fu_ready, input, 3: unit k can accept an instruction this cycle.
REQ-010 SHALL have port flush, input, 1: discard all pending arbitration state.
REQ-011 SHALL have port grant_valid, output, 3: registered, unit k issued an entry.
REQ-012 SHALL have port grant_idx, output, 3 x 5: registered, entry index granted to unit k.
REQ-013 SHALL have port grant_clear, output, NUM_ENT: registered one-hot-per-grant mask of consumed entries, for the station to clear inuse.

Function
REQ-014 SHALL evaluate each cycle and register results; grant visible one cycle after the sampled request (latency 1).
REQ-015 SHALL compute age = (req_rob - rob_head) mod 32 (5-bit wrap) and grant, per unit, the eligible entry with smallest age; tie -> lowest entry index.
REQ-016 SHALL treat entry i eligible for unit k only when req_valid[i], req_fu[i]==k, fu_ready[k], unit k not blocked, and i not in the mask of REQ-018.
REQ-017 SHALL never grant req_fu==3 entries; such entries are ignored, not cleared.
REQ-018 SHALL mask, for exactly one cycle, entries set in the current grant_clear, preventing double grant while the station updates inuse.
REQ-019 SHALL grant at most one entry per unit per cycle and never the same entry to two units.
REQ-020 SHALL load a MEM block counter with MEM_LAT-1 on a MEM grant and suppress MEM eligibility while counter nonzero; counter decrements to 0 and saturates.
REQ-021 SHALL make ALU0/ALU1 unblocked every cycle (latency 1), gated only by fu_ready.
REQ-022 SHALL, when no entry is eligible for unit k, drive grant_valid[k]=0 and hold grant_idx[k] at its previous value.
REQ-023 SHALL, on flush, drive grant_valid=0, grant_clear=0, clear mask and MEM counter on next edge; flush overrides any request in the same cycle.
REQ-024 SHALL, with fu_ready[k] deasserting in the cycle a grant registers, still complete that grant (ready sampled at request cycle only).

Reset
REQ-025 SHALL, on reset high at posedge, set grant_valid=0, grant_idx=0 all units, grant_clear=0, mask=0, MEM counter=0.
REQ-026 SHALL give reset priority over flush and requests; reset mid-MEM-block releases MEM on the first cycle after reset.

Structure
REQ-027 SHALL place fu_id encoding (FU_ALU0, FU_ALU1, FU_MEM, FU_NONE), NUM_FU=3 and NUM_ENT in respackage.
REQ-028 SHALL use one sub-module oldest_select (eligible vector + ages -> found, index) instantiated once per unit.
REQ-029 SHALL be purely synchronous, no latches, no combinational path from inputs to outputs.

Verification
REQ-030 SHALL cover: reset, then entries 3 (rob 7) and 9 (rob 2) req ALU0, rob_head=0 -> next cycle grant_idx[0]=9, grant_clear bit 9, following cycle entry 3.
REQ-031 SHALL cover wrap: rob_head=30, entry 1 rob 31, entry 2 rob 1, both ALU1 -> entry 1 granted first.
REQ-032 SHALL cover MEM_LAT=3: two MEM entries valid continuously -> grants 3 cycles apart, no MEM grant in between.
REQ-033 SHALL cover double-grant guard: entry 5 req_valid held high two cycles after grant -> grant_valid=0 cycle after grant, single grant_clear pulse.
REQ-034 SHALL cover simultaneous ALU0, ALU1, MEM requests with all fu_ready -> three grants same cycle; then flush asserted with requests -> grant_valid=000 next cycle.
REQ-035 SHALL cover fu_ready[0]=0 with ALU0 request pending -> no grant until fu_ready[0]=1, grant one cycle later; req_fu=3 entry never granted.
